predelay_commutator: RTL and testbench
======================================

# predelay_commutator

Front half of the R2MDC inter-stage reorder network. Takes two complex streams from the preceding butterfly, delays path 1 by `DELAY` samples in a circular buffer, then swaps the two paths every `DELAY` samples. The outputs feed `postdelay_commutator`, which applies the matching delay to path 0. The block frames `NUM_PAIRS` input pairs, appends a `DELAY`-cycle drain, and back-pressures the upstream butterfly during that drain.

## Interface
Parameters:
- `DELAY`, default 16: path-1 delay and commutator switch period, in samples. Power of two, ≥2.
- `NUM_PAIRS`, default 32: input pairs per frame. Multiple of `DELAY`, ≥ `DELAY`.
- `DATA_W`, default 16: width of each real/imag component.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - `CLK`  in  1  clock.
  - `RST`  in  1  reset.
- Input side:
  - `in_valid`  in  1  input pair present.
  - `in_ready`  out  1  block accepts an input pair this cycle.
  - `bf_out0_re`, `bf_out0_im`  in  `DATA_W`  path 0 sample.
  - `bf_out1_re`, `bf_out1_im`  in  `DATA_W`  path 1 sample.
- Output side:
  - `out_valid`  out  1  output pair valid, registered.
  - `cm_out0_re`, `cm_out0_im`  out  `DATA_W`  commutated path 0.
  - `cm_out1_re`, `cm_out1_im`  out  `DATA_W`  commutated path 1.
  - `frame_done`  out  1  one-cycle pulse with the last drain output.

## Operation
- Sample index `k` counts steps within a frame, over `0 .. NUM_PAIRS+DELAY-1`.
- A step is one of:
  - an accepted input (`in_valid & in_ready`), or
  - a drain cycle.
- Delay line: `d1[k] = in1[k-DELAY]` for `k ≥ DELAY`.
  - Implemented as read-before-write on the same address of a `DELAY`-deep buffer.
  - `wr_ptr` wraps modulo `DELAY`.
- Switch bit `sel = (k / DELAY) & 1`.
  - `sel=0`: `cm_out0 = in0[k]`, `cm_out1 = d1[k]`.
  - `sel=1`: `cm_out0 = d1[k]`, `cm_out1 = in0[k]`.
- Arithmetic and width: pure data movement, no arithmetic and no width change.
- FSM:
  - `FILL`:
    - Active for `k < DELAY`.
    - `in_ready=1`.
    - Goes to `RUN` after step `k=DELAY-1`.
  - `RUN`:
    - Active for `DELAY ≤ k < NUM_PAIRS`.
    - `in_ready=1`.
    - Goes to `DRAIN` after step `k=NUM_PAIRS-1`.
    - If `NUM_PAIRS == DELAY`, the FSM goes from `FILL` directly to `DRAIN`.
  - `DRAIN`:
    - `in_ready=0`.
    - One step per cycle, with zero injected for `in0` and `in1`.
    - After `DELAY` cycles: `frame_done` pulses, `k` clears to 0, and the FSM returns to `FILL`.
- Idle: no step occurs in a `FILL`/`RUN` cycle with `in_valid=0`. `k`, `wr_ptr`, `sel` and the FSM hold.

## Timing
- Latency: a step at cycle t produces its outputs and `out_valid=1` at t+1.
  - A non-step cycle gives `out_valid=0` at t+1.
  - Output data holds its last value when `out_valid=0`.
- Drain output: `out_valid` stays high for all `DELAY` drain cycles.
- `in_ready` is a function of state only; it does not depend on `in_valid`.
  - The first cycle after the last `RUN` step shows `in_ready=0`.
- Reset values:
  - `out_valid=0`, `frame_done=0`, all `cm_out*` = 0.
  - `in_ready=1`, state `FILL`, `k=0`, `wr_ptr=0`, `sel=0`.
  - Buffer contents are not cleared.
- Reset mid-frame aborts the frame immediately. The next accepted input is `k=0`.
- Wrap-around: `wr_ptr` wrapping from `DELAY-1` to 0 coincides with each `sel` toggle.

## Configuration
- Macro `PREDELAY_ZERO_FILL_EN`:
  - Defined: `d1` is forced to 0 while `k < DELAY`. Every frame starts with a deterministic zero pad.
  - Undefined: `d1` takes raw buffer contents during `FILL`.
    - First frame after reset: X in simulation.
    - Later frames: the previous frame's drain data, which is zero.

## Structure
- Shared package `r2mdc_pkg`:
  - `DATA_W`.
  - Complex sample typedef `cplx_t` (re, im).
  - FSM state enum `pdc_state_t`.
  - Helper `clog2`.
- Sub-module `delay_ram`:
  - `DELAY`-deep, `2*DATA_W`-wide circular buffer.
  - Ports: write enable, registered pointer, read-before-write.
  - Also reusable by `postdelay_commutator`.

## Test plan
Tests 1–5 use `DELAY=4`, `NUM_PAIRS=8`, `in0.re=k`, `in1.re=100+k`, `im=-re`.
1. Continuous `in_valid`, macro defined:
   - `k=0..3` → `cm_out0.re` = 0,1,2,3 and `cm_out1.re` = 0,0,0,0.
   - `k=4..7` → `cm_out0.re` = 100..103 and `cm_out1.re` = 4..7.
   - Drain → `cm_out0.re` = 0,0,0,0 and `cm_out1.re` = 104..107.
   - `frame_done` pulses with the last drain output.
2. `in_valid` toggling 1,0,1,0 → same output sequence as test 1. `out_valid` shows a gap after each idle cycle. `k` and `sel` do not advance on idle cycles.
3. `in_valid` held high through the drain → `in_ready=0` for exactly 4 cycles. No input is accepted; the held input becomes `k=0` of the next frame.
4. Two back-to-back frames, second with `in0.re=10+k` → the second frame's `FILL` outputs `cm_out1.re=0`, with no residue from frame 1.
5. Assert `RST` during `k=5` → next cycle `out_valid=0`, `in_ready=1`. The next input reproduces the first output of test 1.
6. `DELAY=16`, `NUM_PAIRS=32`, random data → output matches a reference model of the delay-then-swap rule across all 48 steps.

Source files
------------

// File: rtl/r2mdc_pkg.sv
// Shared types and helpers for the R2MDC inter-stage reorder network
// (predelay_commutator, postdelay_commutator, delay_ram).
package r2mdc_pkg;

    localparam int DATA_W = 16;

    // Complex sample as carried between butterflies and commutators.
    typedef struct packed {
        logic signed [DATA_W-1:0] re;
        logic signed [DATA_W-1:0] im;
    } cplx_t;

    // Frame sequencing for the pre-delay commutator.
    typedef enum logic [1:0] {
        PDC_FILL  = 2'd0,
        PDC_RUN   = 2'd1,
        PDC_DRAIN = 2'd2
    } pdc_state_t;

    // Ceiling log2, usable in constant expressions.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) result = i + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/delay_ram.sv
// Circular delay buffer: DELAY entries of WIDTH bits. The read port sees the
// entry at the current pointer before this cycle's write replaces it, so a
// write at step k returns the value written DELAY steps earlier.
module delay_ram
    import r2mdc_pkg::*;
#(
    parameter int DELAY = 16,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    localparam int PTR_W = clog2(DELAY);

    logic [WIDTH-1:0] mem [DELAY];
    logic [PTR_W-1:0] ptr;

    // Old contents at the pointer are visible combinationally this cycle.
    assign rdata = mem[ptr];

    // Pointer advances once per write and wraps naturally (DELAY is 2^n).
    always_ff @(posedge clk) begin
        if (rst) ptr <= '0;
        else if (we) ptr <= ptr + PTR_W'(1);
    end

    // Storage is deliberately never cleared.
    always_ff @(posedge clk) begin
        if (we) mem[ptr] <= wdata;
    end

endmodule

// File: rtl/predelay_commutator.sv
// Front half of the R2MDC reorder network: delays path 1 by DELAY samples,
// then swaps the paths every DELAY samples. Each frame is NUM_PAIRS inputs
// followed by a DELAY-cycle drain that back-pressures the upstream butterfly.
// Optional macro PREDELAY_ZERO_FILL_EN forces the delayed path to zero while
// the buffer is filling, giving every frame a deterministic zero pad.
module predelay_commutator #(
    parameter int DELAY     = 16,
    parameter int NUM_PAIRS = 32,
    parameter int DATA_W    = 16
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] bf_out0_re,
    input  logic signed [DATA_W-1:0] bf_out0_im,
    input  logic signed [DATA_W-1:0] bf_out1_re,
    input  logic signed [DATA_W-1:0] bf_out1_im,
    output logic                     out_valid,
    output logic signed [DATA_W-1:0] cm_out0_re,
    output logic signed [DATA_W-1:0] cm_out0_im,
    output logic signed [DATA_W-1:0] cm_out1_re,
    output logic signed [DATA_W-1:0] cm_out1_im,
    output logic                     frame_done
);

    import r2mdc_pkg::pdc_state_t;
    import r2mdc_pkg::PDC_FILL;
    import r2mdc_pkg::PDC_RUN;
    import r2mdc_pkg::PDC_DRAIN;
    import r2mdc_pkg::clog2;

    localparam int PTR_W = clog2(DELAY);
    localparam int TOTAL = NUM_PAIRS + DELAY;
    localparam int K_W   = clog2(TOTAL) + 1;

    localparam logic [K_W-1:0] K_FILL_END = K_W'(DELAY - 1);
    localparam logic [K_W-1:0] K_RUN_END  = K_W'(NUM_PAIRS - 1);
    localparam logic [K_W-1:0] K_LAST     = K_W'(TOTAL - 1);

    pdc_state_t state, state_nxt;
    logic [K_W-1:0] k;
    logic step;
    logic sel;
    logic last_drain;

    logic signed [DATA_W-1:0] in0_re, in0_im, in1_re, in1_im;
    logic signed [DATA_W-1:0] d1_re, d1_im;
    logic [2*DATA_W-1:0] rd_data;

    // Switch period equals DELAY (a power of two), so sel is one bit of k;
    // it toggles exactly when the buffer pointer wraps.
    assign sel        = k[PTR_W];
    assign last_drain = (state == PDC_DRAIN) && (k == K_LAST);

    // Ready depends on state only; drain cycles are steps without input.
    always_comb begin
        state_nxt = state;
        in_ready  = (state != PDC_DRAIN);
        step      = (state != PDC_DRAIN) ? in_valid : 1'b1;
        case (state)
            PDC_FILL: begin
                if (step && k == K_FILL_END)
                    state_nxt = (NUM_PAIRS == DELAY) ? PDC_DRAIN : PDC_RUN;
            end
            PDC_RUN: begin
                if (step && k == K_RUN_END) state_nxt = PDC_DRAIN;
            end
            PDC_DRAIN: begin
                if (k == K_LAST) state_nxt = PDC_FILL;
            end
            default: state_nxt = PDC_FILL;
        endcase
    end

    // FSM state register.
    always_ff @(posedge CLK) begin
        if (RST) state <= PDC_FILL;
        else     state <= state_nxt;
    end

    // Step index within the frame; holds on idle cycles.
    always_ff @(posedge CLK) begin
        if (RST)       k <= '0;
        else if (step) k <= (k == K_LAST) ? '0 : k + K_W'(1);
    end

    // Zeros are injected on both paths during the drain.
    always_comb begin
        in0_re = bf_out0_re;
        in0_im = bf_out0_im;
        in1_re = bf_out1_re;
        in1_im = bf_out1_im;
        if (state == PDC_DRAIN) begin
            in0_re = '0;
            in0_im = '0;
            in1_re = '0;
            in1_im = '0;
        end
    end

    delay_ram #(
        .DELAY (DELAY),
        .WIDTH (2 * DATA_W)
    ) u_delay_ram (
        .clk   (CLK),
        .rst   (RST),
        .we    (step),
        .wdata ({in1_re, in1_im}),
        .rdata (rd_data)
    );

    // Delayed path 1, optionally masked while the buffer is still filling.
    always_comb begin
        d1_re = rd_data[2*DATA_W-1:DATA_W];
        d1_im = rd_data[DATA_W-1:0];
`ifdef PREDELAY_ZERO_FILL_EN
        if (state == PDC_FILL) begin
            d1_re = '0;
            d1_im = '0;
        end
`endif
    end

    // Output control: one valid per step, frame_done with the last drain step.
    always_ff @(posedge CLK) begin
        if (RST) begin
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            out_valid  <= step;
            frame_done <= last_drain;
        end
    end

    // Commutated output data; holds its value on non-step cycles.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cm_out0_re <= '0;
            cm_out0_im <= '0;
            cm_out1_re <= '0;
            cm_out1_im <= '0;
        end else if (step) begin
            if (sel) begin
                cm_out0_re <= d1_re;
                cm_out0_im <= d1_im;
                cm_out1_re <= in0_re;
                cm_out1_im <= in0_im;
            end else begin
                cm_out0_re <= in0_re;
                cm_out0_im <= in0_im;
                cm_out1_re <= d1_re;
                cm_out1_im <= d1_im;
            end
        end
    end

endmodule

// File: tb/tb_predelay_commutator.sv
// Bench for predelay_commutator: directed frames on a DELAY=4/NUM_PAIRS=8
// instance and randomized traffic on a DELAY=16/NUM_PAIRS=32 instance, both
// checked against a frame-level model of the delay-then-swap rule.
module tb_predelay_commutator;

`ifdef PREDELAY_ZERO_FILL_EN
    localparam bit ZF = 1'b1;
`else
    localparam bit ZF = 1'b0;
`endif

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic               rst_s [2];
    logic               vld   [2];
    logic               rdy   [2];
    logic signed [15:0] i0re  [2];
    logic signed [15:0] i0im  [2];
    logic signed [15:0] i1re  [2];
    logic signed [15:0] i1im  [2];
    logic               ov    [2];
    logic signed [15:0] o0re  [2];
    logic signed [15:0] o0im  [2];
    logic signed [15:0] o1re  [2];
    logic signed [15:0] o1im  [2];
    logic               fd    [2];

    predelay_commutator #(.DELAY(4), .NUM_PAIRS(8), .DATA_W(16)) dut_a (
        .CLK(CLK), .RST(rst_s[0]), .in_valid(vld[0]), .in_ready(rdy[0]),
        .bf_out0_re(i0re[0]), .bf_out0_im(i0im[0]),
        .bf_out1_re(i1re[0]), .bf_out1_im(i1im[0]),
        .out_valid(ov[0]),
        .cm_out0_re(o0re[0]), .cm_out0_im(o0im[0]),
        .cm_out1_re(o1re[0]), .cm_out1_im(o1im[0]),
        .frame_done(fd[0])
    );

    predelay_commutator #(.DELAY(16), .NUM_PAIRS(32), .DATA_W(16)) dut_b (
        .CLK(CLK), .RST(rst_s[1]), .in_valid(vld[1]), .in_ready(rdy[1]),
        .bf_out0_re(i0re[1]), .bf_out0_im(i0im[1]),
        .bf_out1_re(i1re[1]), .bf_out1_im(i1im[1]),
        .out_valid(ov[1]),
        .cm_out0_re(o0re[1]), .cm_out0_im(o0im[1]),
        .cm_out1_re(o1re[1]), .cm_out1_im(o1im[1]),
        .frame_done(fd[1])
    );

    int checks = 0;
    int errors = 0;

    // Frame-level reference model, one slot per instance.
    int          md [2] = '{4, 16};
    int          mn [2] = '{8, 32};
    int          mk [2];
    bit          mfirst [2];
    logic [31:0] hist1 [2][64];
    logic [31:0] lo0 [2];
    logic [31:0] lo1 [2];
    bit          lk0 [2];
    bit          lk1 [2];

    function automatic logic [31:0] pk(input int re, input int im);
        return {16'(re), 16'(im)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset(input int u, input bit v);
        rst_s[u] = 1'b1;
        vld[u]   = v;
        @(posedge CLK); #1;
        chk($sformatf("rst_out_valid%0d", u), {31'b0, ov[u]}, 32'd0);
        chk($sformatf("rst_frame_done%0d", u), {31'b0, fd[u]}, 32'd0);
        chk($sformatf("rst_in_ready%0d", u), {31'b0, rdy[u]}, 32'd1);
        chk($sformatf("rst_out0_%0d", u), {o0re[u], o0im[u]}, 32'd0);
        chk($sformatf("rst_out1_%0d", u), {o1re[u], o1im[u]}, 32'd0);
        rst_s[u]  = 1'b0;
        mk[u]     = 0;
        mfirst[u] = 1'b1;
        lo0[u] = '0; lo1[u] = '0;
        lk0[u] = 1'b1; lk1[u] = 1'b1;
    endtask

    // One clock cycle: drive a pair, advance, and check the registered result.
    task automatic cyc(input int u, input bit v, input int r0, input int m0,
                       input int r1, input int m1);
        bit er, st, sw, dk;
        int kk;
        logic [31:0] x0, x1, d1;
        er = (mk[u] < mn[u]);
        chk($sformatf("in_ready%0d_k%0d", u, mk[u]), {31'b0, rdy[u]}, {31'b0, er});
        vld[u]  = v;
        i0re[u] = 16'(r0); i0im[u] = 16'(m0);
        i1re[u] = 16'(r1); i1im[u] = 16'(m1);
        st = er ? v : 1'b1;
        @(posedge CLK); #1;
        if (st) begin
            kk = mk[u];
            x0 = er ? pk(r0, m0) : 32'd0;
            x1 = er ? pk(r1, m1) : 32'd0;
            hist1[u][kk] = x1;
            if (kk >= md[u]) begin
                d1 = hist1[u][kk - md[u]];
                dk = 1'b1;
            end else begin
                d1 = 32'd0;
                dk = ZF || !mfirst[u];
            end
            sw = ((kk / md[u]) % 2) == 1;
            if (sw) begin
                lo0[u] = d1; lk0[u] = dk; lo1[u] = x0; lk1[u] = 1'b1;
            end else begin
                lo0[u] = x0; lk0[u] = 1'b1; lo1[u] = d1; lk1[u] = dk;
            end
            chk($sformatf("out_valid%0d_k%0d", u, kk), {31'b0, ov[u]}, 32'd1);
            chk($sformatf("frame_done%0d_k%0d", u, kk), {31'b0, fd[u]},
                {31'b0, (kk == mn[u] + md[u] - 1)});
            mk[u]++;
            if (mk[u] == mn[u] + md[u]) begin
                mk[u]     = 0;
                mfirst[u] = 1'b0;
            end
        end else begin
            chk($sformatf("idle_out_valid%0d_k%0d", u, mk[u]), {31'b0, ov[u]}, 32'd0);
            chk($sformatf("idle_frame_done%0d", u), {31'b0, fd[u]}, 32'd0);
        end
        if (lk0[u]) chk($sformatf("cm_out0_%0d_k%0d", u, mk[u]), {o0re[u], o0im[u]}, lo0[u]);
        if (lk1[u]) chk($sformatf("cm_out1_%0d_k%0d", u, mk[u]), {o1re[u], o1im[u]}, lo1[u]);
    endtask

    initial begin
        int r0, r1, m0, m1;
        for (int u = 0; u < 2; u++) begin
            rst_s[u] = 1'b1; vld[u] = 1'b0;
            i0re[u] = '0; i0im[u] = '0; i1re[u] = '0; i1im[u] = '0;
        end
        do_reset(0, 1'b0);
        do_reset(1, 1'b0);

        // Continuous frame.
        for (int k = 0; k < 8; k++) cyc(0, 1'b1, k, -k, 100 + k, -(100 + k));
        for (int k = 0; k < 4; k++) cyc(0, 1'b0, 0, 0, 0, 0);

        // in_valid toggling: each accepted pair followed by an idle cycle.
        for (int k = 0; k < 8; k++) begin
            cyc(0, 1'b1, k, -k, 100 + k, -(100 + k));
            cyc(0, 1'b0, 999, 7, 555, 3);
        end
        for (int k = 0; k < 4; k++) cyc(0, 1'b0, 0, 0, 0, 0);

        // in_valid held through the drain, then a second back-to-back frame.
        for (int k = 0; k < 8; k++) cyc(0, 1'b1, k, -k, 100 + k, -(100 + k));
        for (int k = 0; k < 4; k++) cyc(0, 1'b1, 10, -10, 100, -100);
        for (int k = 0; k < 8; k++) cyc(0, 1'b1, 10 + k, -(10 + k), 100 + k, -(100 + k));
        for (int k = 0; k < 4; k++) cyc(0, 1'b0, 0, 0, 0, 0);

        // Reset mid-frame at k=5, then a fresh frame.
        for (int k = 0; k < 5; k++) cyc(0, 1'b1, k, -k, 100 + k, -(100 + k));
        i0re[0] = 16'(5); i0im[0] = -16'(5); i1re[0] = 16'(105); i1im[0] = -16'(105);
        do_reset(0, 1'b1);
        for (int k = 0; k < 8; k++) cyc(0, 1'b1, k, -k, 100 + k, -(100 + k));
        for (int k = 0; k < 4; k++) cyc(0, 1'b0, 0, 0, 0, 0);

        // Large configuration with random data and random valid gaps.
        for (int c = 0; c < 240; c++) begin
            r0 = int'($urandom_range(0, 65535));
            m0 = int'($urandom_range(0, 65535));
            r1 = int'($urandom_range(0, 65535));
            m1 = int'($urandom_range(0, 65535));
            cyc(1, ($urandom_range(0, 3) != 0), r0, m0, r1, m1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
